// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-channel active-low push-button front end.
// Each key is synchronised, debounced and classified into press/release/long/repeat strobes.
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int DB_CYCLES    = 2000000,
  parameter int TICK_CYCLES  = 100000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                key_flag
);

  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int TICK_W   = $clog2(TICK_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  // Two-flop synchroniser; idles at 1 (released) so reset never fakes a press.
  logic [NUM_KEYS-1:0] key_meta_q;
  logic [NUM_KEYS-1:0] key_s_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta_q <= '1;
      key_s_q    <= '1;
    end else begin
      key_meta_q <= key;
      key_s_q    <= key_meta_q;
    end
  end

  // Shared hold-timing prescaler.
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              tick;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  logic [NUM_KEYS-1:0] event_d;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    logic              key_value_q;
    logic              key_value_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              long_q;
    logic              long_d;
    logic              repeat_q;
    logic              repeat_d;
    hold_state_e       state_q;
    hold_state_e       state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    // Any cycle matching the accepted level restarts the count from zero.
    always_comb begin
      key_value_d = key_value_q;
      db_cnt_d    = '0;
      press_d     = 1'b0;
      release_d   = 1'b0;
      if (key_s_q[gi] != key_value_q) begin
        if (db_cnt_q == DB_LAST) begin
          key_value_d = key_s_q[gi];
          press_d     = ~key_s_q[gi];
          release_d   = key_s_q[gi];
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    // Edge events take priority over a coincident tick.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d    = HELD;
            hold_cnt_d = '0;
          end
        end
        HELD: begin
          if (release_d) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (tick) begin
            if (hold_cnt_q == LONG_LAST) begin
              long_d     = 1'b1;
              state_d    = LONG;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        LONG: begin
          if (release_d) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (tick) begin
            if (hold_cnt_q == REPEAT_LAST) begin
              repeat_d   = REPEAT_EN;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        key_value_q <= 1'b1;
        db_cnt_q    <= '0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
        state_q     <= IDLE;
        hold_cnt_q  <= '0;
      end else begin
        key_value_q <= key_value_d;
        db_cnt_q    <= db_cnt_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
        state_q     <= state_d;
        hold_cnt_q  <= hold_cnt_d;
      end
    end

    assign key_value[gi]     = key_value_q;
    assign press_pulse[gi]   = press_q;
    assign release_pulse[gi] = release_q;
    assign long_pulse[gi]    = long_q;
    assign repeat_pulse[gi]  = repeat_q;
    assign event_d[gi]       = press_d | release_d | long_d | repeat_d;
  end

  logic key_flag_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flag_q <= 1'b0;
    end else begin
      key_flag_q <= |event_d;
    end
  end

  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short timing parameters.
// A second instance with auto-repeat disabled shares the same stimulus.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int DB = 16;
  localparam int TC = 10;
  localparam int LT = 5;
  localparam int RT = 3;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NK-1:0] key       = 4'hF;

  logic [NK-1:0] key_value, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic          key_flag;
  logic [NK-1:0] kv2, pp2, rp2, lp2, rep2;
  logic          kf2;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  key_debounce_multi #(
    .NUM_KEYS(NK), .DB_CYCLES(DB), .TICK_CYCLES(TC),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b1)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_value(key_value), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .key_flag(key_flag)
  );

  key_debounce_multi #(
    .NUM_KEYS(NK), .DB_CYCLES(DB), .TICK_CYCLES(TC),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b0)
  ) u_dut_norep (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_value(kv2), .press_pulse(pp2), .release_pulse(rp2),
    .long_pulse(lp2), .repeat_pulse(rep2), .key_flag(kf2)
  );

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key       = 4'hF;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({key_value, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag} !== {4'hF, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_asserted: kv=%b pp=%b rp=%b lp=%b rep=%b flag=%b required kv=1111 pulses=0 flag=0",
               key_value, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag);
    end
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({key_value, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag} !== {4'hF, 16'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: kv=%b pp=%b rp=%b lp=%b rep=%b flag=%b required kv=1111 pulses=0 flag=0",
                 i, key_value, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_bounce();
    int bad = 0;
    int pidx = -1, np = 0, ridx = -1, nr = 0, nl = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge sys_clk);
      if (press_pulse[0] || release_pulse[0] || key_value[0] !== 1'b1) bad++;
      if (t % 5 == 0) key[0] = ~key[0];
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounce_quiet: %0d disturbed cycles, required 0", bad);
    end
    key[0] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge sys_clk);
      if (press_pulse[0]) begin
        np++;
        if (pidx < 0) pidx = i;
      end
      if (long_pulse[0]) nl++;
    end
    checks++;
    if (pidx !== 18 || np !== 1) begin
      errors++;
      $display("FAIL bounce_press: edge %0d count %0d, required edge 18 count 1", pidx, np);
    end
    checks++;
    if (key_value[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level: key_value[0]=%b required 0", key_value[0]);
    end
    key[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge sys_clk);
      if (release_pulse[0]) begin
        nr++;
        if (ridx < 0) ridx = i;
      end
      if (long_pulse[0]) nl++;
    end
    checks++;
    if (ridx !== 18 || nr !== 1 || nl !== 0) begin
      errors++;
      $display("FAIL bounce_release: edge %0d count %0d longs %0d, required edge 18 count 1 longs 0", ridx, nr, nl);
    end
    $display("test_bounce: press at edge %0d, release at edge %0d", pidx, ridx);
  endtask

  task automatic test_glitch();
    int ev = 0;
    int pidx = -1, np = 0, ridx = -1, nr = 0;
    key[0] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge sys_clk);
      if (press_pulse[0] || release_pulse[0] || key_value[0] !== 1'b1) ev++;
      if (i == 15) key[0] = 1'b1;
    end
    checks++;
    if (ev !== 0) begin
      errors++;
      $display("FAIL glitch_15: %0d disturbed cycles, required 0", ev);
    end
    key[0] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge sys_clk);
      if (press_pulse[0]) begin
        np++;
        if (pidx < 0) pidx = i;
      end
      if (release_pulse[0]) begin
        nr++;
        if (ridx < 0) ridx = i;
      end
      if (i == 16) key[0] = 1'b1;
    end
    checks++;
    if (pidx !== 18 || np !== 1) begin
      errors++;
      $display("FAIL glitch_16_press: edge %0d count %0d, required edge 18 count 1", pidx, np);
    end
    checks++;
    if (ridx !== 34 || nr !== 1) begin
      errors++;
      $display("FAIL glitch_16_release: edge %0d count %0d, required edge 34 count 1", ridx, nr);
    end
    $display("test_glitch: 16-cycle press at %0d, release at %0d", pidx, ridx);
  endtask

  task automatic test_long_repeat();
    int pidx = -1, ridx = -1, lidx = -1, nl = 0, nrep = 0;
    int lidx2 = -1, nrep2 = 0, flag_bad = 0;
    int rep_at[8];
    key[1] = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge sys_clk);
      if (press_pulse[1] && pidx < 0) pidx = i;
      if (release_pulse[1] && ridx < 0) ridx = i;
      if (long_pulse[1]) begin
        nl++;
        if (lidx < 0) lidx = i;
      end
      if (repeat_pulse[1]) begin
        if (nrep < 8) rep_at[nrep] = i;
        nrep++;
      end
      if (lp2[1] && lidx2 < 0) lidx2 = i;
      if (rep2 != 4'h0) nrep2++;
      if (key_flag !== (|{press_pulse, release_pulse, long_pulse, repeat_pulse})) flag_bad++;
      if (i == 150) key[1] = 1'b1;
    end
    checks++;
    if (pidx !== 18) begin
      errors++;
      $display("FAIL long_press: edge %0d required 18", pidx);
    end
    checks++;
    if (nl !== 1 || lidx - pidx < (LT - 1) * TC + 1 || lidx - pidx > LT * TC) begin
      errors++;
      $display("FAIL long_timing: %0d longs, %0d cycles after press, required 1 long within 41..50", nl, lidx - pidx);
    end
    checks++;
    if (nrep !== 3) begin
      errors++;
      $display("FAIL repeat_count: %0d required 3", nrep);
    end else begin
      checks++;
      if (rep_at[0] - lidx !== RT * TC || rep_at[1] - rep_at[0] !== RT * TC || rep_at[2] - rep_at[1] !== RT * TC) begin
        errors++;
        $display("FAIL repeat_spacing: gaps %0d %0d %0d required 30 30 30",
                 rep_at[0] - lidx, rep_at[1] - rep_at[0], rep_at[2] - rep_at[1]);
      end
    end
    checks++;
    if (ridx !== 168) begin
      errors++;
      $display("FAIL long_release: edge %0d required 168", ridx);
    end
    checks++;
    if (lidx2 !== lidx || nrep2 !== 0) begin
      errors++;
      $display("FAIL norepeat: long edge %0d repeats %0d, required long edge %0d repeats 0", lidx2, nrep2, lidx);
    end
    checks++;
    if (flag_bad !== 0) begin
      errors++;
      $display("FAIL flag_coincident: %0d cycles off, required 0", flag_bad);
    end
    $display("test_long_repeat: press %0d long %0d repeats %0d release %0d", pidx, lidx, nrep, ridx);
  endtask

  task automatic test_simultaneous();
    int np = 0, pidx = -1, nf = 0, fidx = -1, nr = 0, ridx = -1;
    logic [NK-1:0] pval = '0;
    logic [NK-1:0] rval = '0;
    key[3:2] = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      @(negedge sys_clk);
      if (press_pulse != 4'h0) begin
        np++;
        pidx = i;
        pval = press_pulse;
      end
      if (key_flag) begin
        nf++;
        fidx = i;
      end
    end
    checks++;
    if (np !== 1 || pidx !== 18 || pval !== 4'b1100) begin
      errors++;
      $display("FAIL simul_press: %0d cycles, last edge %0d value %b, required 1 cycle at 18 value 1100", np, pidx, pval);
    end
    checks++;
    if (nf !== 1 || fidx !== 18) begin
      errors++;
      $display("FAIL simul_flag: %0d cycles, last edge %0d, required 1 cycle at 18", nf, fidx);
    end
    key[3:2] = 2'b11;
    for (int i = 1; i <= 30; i++) begin
      @(negedge sys_clk);
      if (release_pulse != 4'h0) begin
        nr++;
        ridx = i;
        rval = release_pulse;
      end
    end
    checks++;
    if (nr !== 1 || ridx !== 18 || rval !== 4'b1100) begin
      errors++;
      $display("FAIL simul_release: %0d cycles, last edge %0d value %b, required 1 cycle at 18 value 1100", nr, ridx, rval);
    end
    $display("test_simultaneous: press %b at %0d, release %b at %0d", pval, pidx, rval, ridx);
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int pidx = -1, np = 0, lidx = -1, ridx = -1;
    key[1] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge sys_clk);
      if (long_pulse[1]) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_long: no long_pulse[1] within 80 cycles, required one");
    end
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({key_value, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag, kv2} !== {4'hF, 16'h0, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL mid_async_reset: kv=%b kv2=%b pulses=%b%b%b%b flag=%b required kv=1111 kv2=1111 pulses 0 flag 0",
               key_value, kv2, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge sys_clk);
      if (press_pulse[1]) begin
        np++;
        if (pidx < 0) pidx = i;
      end
      if (long_pulse[1] && lidx < 0) lidx = i;
    end
    checks++;
    if (pidx !== 18 || np !== 1) begin
      errors++;
      $display("FAIL mid_repress: edge %0d count %0d, required edge 18 count 1", pidx, np);
    end
    checks++;
    if (lidx < 0 || lidx - pidx < (LT - 1) * TC + 1 || lidx - pidx > LT * TC) begin
      errors++;
      $display("FAIL mid_relong: long edge %0d press edge %0d, required gap 41..50", lidx, pidx);
    end
    key[1] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge sys_clk);
      if (release_pulse[1] && ridx < 0) ridx = i;
    end
    checks++;
    if (ridx !== 18) begin
      errors++;
      $display("FAIL mid_release: edge %0d required 18", ridx);
    end
    $display("test_reset_mid: repress %0d long %0d release %0d", pidx, lidx, ridx);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_glitch();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button front end for the ranging board's control panel. Each of NUM_KEYS active-low keys is synchronised, debounced, and classified into one-cycle press, release, long-press and auto-repeat events. Downstream mode/trigger logic consumes the event pulses directly, and a shared millisecond-scale tick prescaler keeps hold-timing counters narrow.

## Interface
- NUM_KEYS, 4: number of independent key channels (>=1).
- DB_CYCLES, 2000000: clock cycles a new level must persist before acceptance (20 ms at 100 MHz; >=2).
- TICK_CYCLES, 100000: prescaler period in clocks (1 ms at 100 MHz; >=2).
- LONG_TICKS, 1000: ticks held before long_pulse (>=1).
- REPEAT_TICKS, 200: ticks between repeat_pulse while still held (>=1).
- REPEAT_EN, 1: 1 enables auto-repeat, 0 suppresses repeat_pulse.
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key  in  NUM_KEYS  raw asynchronous key levels, 0 = pressed.
- key_value  out  NUM_KEYS  debounced level per key.
- press_pulse  out  NUM_KEYS  one-cycle strobe on debounced 1->0.
- release_pulse  out  NUM_KEYS  one-cycle strobe on debounced 0->1.
- long_pulse  out  NUM_KEYS  one-cycle strobe when hold reaches LONG_TICKS.
- repeat_pulse  out  NUM_KEYS  one-cycle strobe every REPEAT_TICKS after long.
- key_flag  out  1  OR of all event bits of all channels, same cycle.

## Operation
- Reset values: key_value all 1; every pulse output and key_flag 0; synchronisers 1; all counters 0; prescaler 0; all channels IDLE.
- Synchroniser: two flops per channel, key_s = key delayed 2 clocks.
- Debounce per channel: if key_s == key_value then db_cnt <= 0; else db_cnt increments; when db_cnt == DB_CYCLES-1 and still differing, key_value <= key_s, db_cnt <= 0, and press_pulse or release_pulse asserts in the same cycle key_value updates.
- Any single cycle of key_s returning to key_value clears db_cnt (glitch rejection; no partial credit).
- Prescaler: free-running from reset, tick strobe high one cycle every TICK_CYCLES clocks, shared by all channels.
- Hold FSM per channel: IDLE, HELD, LONG.
  - IDLE: on press event -> HELD, hold_cnt <= 0.
  - HELD: on tick hold_cnt++; on the tick making hold_cnt == LONG_TICKS: long_pulse, -> LONG, hold_cnt <= 0.
  - LONG: on tick hold_cnt++; on reaching REPEAT_TICKS: repeat_pulse (if REPEAT_EN), hold_cnt <= 0.
  - Release event from HELD or LONG -> IDLE, hold_cnt <= 0; no long/repeat in that cycle.
- Priority: press/release event beats a coincident tick (tick not counted).
- Channels fully independent; multiple bits of any pulse vector may assert in one cycle.
- Counter widths: $clog2(limit+1) of each parameter; no wrap possible since counters clear at limit.

## Timing
- Input change held stable: key_value and edge pulse update on the (DB_CYCLES+2)th rising edge after the change.
- All outputs registered; pulses exactly one cycle wide; key_flag coincident with its source pulse.
- long_pulse occurs between (LONG_TICKS-1)*TICK_CYCLES+1 and LONG_TICKS*TICK_CYCLES cycles after press_pulse (tick-phase quantisation); subsequent repeats exactly REPEAT_TICKS*TICK_CYCLES cycles apart.
- long_pulse/repeat_pulse assert the cycle after the qualifying tick strobe.
- Reset mid-operation: all state returns to reset values asynchronously; a key held low through reset release yields a fresh press_pulse DB_CYCLES+2 edges later (synchroniser reset to 1).

## Test plan
Bench parameters: NUM_KEYS=4, DB_CYCLES=16, TICK_CYCLES=10, LONG_TICKS=5, REPEAT_TICKS=3, REPEAT_EN=1.
- Reset with key=4'b1111 -> key_value=4'b1111, all pulses and key_flag 0, held for 100 cycles.
- key[0] toggles every 5 cycles for 60 cycles then stays 0 -> no pulses during bouncing; key_value[0] falls and press_pulse[0] fires once, 18 edges after final edge.
- key[0] low 15 cycles then high -> no change, no pulses; low 16 cycles -> accepted.
- key[1] held low 150 cycles then high -> press; long_pulse[1] 41-50 cycles later; repeat_pulse[1] every 30 cycles; release_pulse[1] 18 edges after release, no further repeats; REPEAT_EN=0 rerun -> no repeat_pulse.
- key[2] and key[3] fall same cycle -> press_pulse=4'b1100 in one cycle, key_flag high exactly one cycle.
- sys_rst_n low 3 cycles while key[1] in LONG and held -> outputs reset immediately; after release, press_pulse[1] 18 edges later, long sequence restarts.
